// File: rtl/alu_exec_ctrl_pkg.sv
// Shared instruction codes and helpers for the execute-stage sequencer.
package alu_exec_ctrl_pkg;

    localparam logic [5:0] i_add   = 6'd0;
    localparam logic [5:0] i_sub   = 6'd1;
    localparam logic [5:0] i_and   = 6'd2;
    localparam logic [5:0] i_or    = 6'd3;
    localparam logic [5:0] i_xor   = 6'd4;
    localparam logic [5:0] i_sll   = 6'd5;
    localparam logic [5:0] i_srl   = 6'd6;
    localparam logic [5:0] i_sra   = 6'd7;
    localparam logic [5:0] i_slt   = 6'd8;
    localparam logic [5:0] i_sltu  = 6'd9;
    localparam logic [5:0] i_addi  = 6'd10;
    localparam logic [5:0] i_auipc = 6'd11;
    localparam logic [5:0] i_lui   = 6'd12;
    localparam logic [5:0] i_beq   = 6'd16;
    localparam logic [5:0] i_bne   = 6'd17;
    localparam logic [5:0] i_blt   = 6'd18;
    localparam logic [5:0] i_bge   = 6'd19;
    localparam logic [5:0] i_bltu  = 6'd20;
    localparam logic [5:0] i_bgeu  = 6'd21;
    localparam logic [5:0] i_jal   = 6'd22;
    localparam logic [5:0] i_jalr  = 6'd23;
    localparam logic [5:0] i_lb    = 6'd24;
    localparam logic [5:0] i_lh    = 6'd25;
    localparam logic [5:0] i_lw    = 6'd26;
    localparam logic [5:0] i_lbu   = 6'd27;
    localparam logic [5:0] i_lhu   = 6'd28;
    localparam logic [5:0] i_sb    = 6'd29;
    localparam logic [5:0] i_sh    = 6'd30;
    localparam logic [5:0] i_sw    = 6'd31;

    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_mem;
        logic is_store;
        logic writes_rd;
    } cls_t;

    // Jumps borrow existing ALU ops: JAL computes pc+imm, JALR computes rs1+imm.
    function automatic logic [5:0] alu_op_remap(input logic [5:0] instr);
        logic [5:0] op;
        op = instr;
        if (instr == i_jal)  op = i_auipc;
        if (instr == i_jalr) op = i_addi;
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_classify.sv
// Combinational instruction class decode, shared with hazard logic.
module alu_exec_ctrl_classify
    import alu_exec_ctrl_pkg::*;
(
    input  logic [5:0] i_instr,
    output cls_t       o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_instr)
            i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu: o_cls.is_branch = 1'b1;
            i_jal, i_jalr:                              o_cls.is_jump   = 1'b1;
            i_lb, i_lh, i_lw, i_lbu, i_lhu:             o_cls.is_mem    = 1'b1;
            i_sb, i_sh, i_sw: begin
                o_cls.is_mem   = 1'b1;
                o_cls.is_store = 1'b1;
            end
            default: ;
        endcase
        // Unknown codes fall through as plain ALU ops.
        o_cls.writes_rd = ~o_cls.is_branch & ~o_cls.is_mem;
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: feeds the registered-input ALU, captures and
// classifies its result, and presents one packet downstream with backpressure.
//   state | meaning
//   IDLE  | ready for a new instruction from decode
//   EXEC  | hold registers on alu_*, ALU samples them at end of cycle
//   CAPT  | alu_result valid, packet fields registered
//   DONE  | packet presented until out_ready
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_instr,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [4:0]       in_shamt,
    input  logic [31:0]      in_pc,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic [5:0]       alu_instr,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [WIDTH-1:0] alu_imm,
    output logic [4:0]       alu_shamt,
    output logic [31:0]      alu_pc,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_instr,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_mem,
    output logic             out_is_store,
    output logic [WIDTH-1:0] out_mem_addr,
    output logic [WIDTH-1:0] out_store_data,
    output logic             out_redirect,
    output logic [31:0]      out_target
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state, w_next;
    logic [5:0]       r_instr;
    logic [WIDTH-1:0] r_rs1, r_rs2, r_imm;
    logic [4:0]       r_shamt, r_rd;
    logic [31:0]      r_pc;
    logic             w_accept;
    cls_t             w_cls;
    logic [31:0]      w_link, w_br_target;

    assign w_accept = (r_state == S_IDLE) & in_valid & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_next = S_EXEC;
                S_EXEC:  w_next = S_CAPT;
                S_CAPT:  w_next = S_DONE;
                S_DONE:  if (out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Reset input gates in_ready so it stays low while reset is held.
    always_comb begin
        in_ready  = (r_state == S_IDLE) & rst;
        out_valid = (r_state == S_DONE) & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_imm   <= '0;
            r_shamt <= '0;
            r_pc    <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_instr <= in_instr;
            r_rs1   <= in_rs1;
            r_rs2   <= in_rs2;
            r_imm   <= in_imm;
            r_shamt <= in_shamt;
            r_pc    <= in_pc;
            r_rd    <= in_rd;
        end
    end

    assign alu_instr = alu_op_remap(r_instr);
    assign alu_rs1   = r_rs1;
    assign alu_rs2   = r_rs2;
    assign alu_imm   = r_imm;
    assign alu_shamt = r_shamt;
    assign alu_pc    = r_pc;

    alu_exec_ctrl_classify u_classify (
        .i_instr (r_instr),
        .o_cls   (w_cls)
    );

    assign w_link      = r_pc + 32'd4;
    assign w_br_target = r_pc + r_imm[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_instr      <= '0;
            out_rd         <= '0;
            out_we         <= 1'b0;
            out_data       <= '0;
            out_is_mem     <= 1'b0;
            out_is_store   <= 1'b0;
            out_mem_addr   <= '0;
            out_store_data <= '0;
            out_redirect   <= 1'b0;
            out_target     <= '0;
        end else if (r_state == S_CAPT) begin
            out_instr      <= r_instr;
            out_rd         <= r_rd;
            out_we         <= w_cls.writes_rd & (r_rd != 5'd0);
            out_is_mem     <= w_cls.is_mem;
            out_is_store   <= w_cls.is_store;
            out_mem_addr   <= w_cls.is_mem   ? alu_result : '0;
            out_store_data <= w_cls.is_store ? r_rs2      : '0;
            if (w_cls.is_jump)
                out_data <= WIDTH'(w_link);
            else if (w_cls.writes_rd)
                out_data <= alu_result;
            else
                out_data <= '0;
            // Branch outcome lives only in result bit 0; upper bits are don't-care.
            if (w_cls.is_branch) begin
                out_redirect <= alu_result[0];
                out_target   <= w_br_target;
            end else if (w_cls.is_jump) begin
                out_redirect <= 1'b1;
                out_target   <= (r_instr == i_jalr) ? {alu_result[31:1], 1'b0}
                                                    : alu_result[31:0];
            end else begin
                out_redirect <= 1'b0;
                out_target   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a registered-input ALU model.
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [5:0]       in_instr;
    logic [WIDTH-1:0] in_rs1, in_rs2, in_imm;
    logic [4:0]       in_shamt, in_rd;
    logic [31:0]      in_pc;
    logic             flush;
    logic [5:0]       alu_instr;
    logic [WIDTH-1:0] alu_rs1, alu_rs2, alu_imm, alu_result;
    logic [4:0]       alu_shamt;
    logic [31:0]      alu_pc;
    logic             out_valid, out_ready;
    logic [5:0]       out_instr;
    logic [4:0]       out_rd;
    logic             out_we, out_is_mem, out_is_store, out_redirect;
    logic [WIDTH-1:0] out_data, out_mem_addr, out_store_data;
    logic [31:0]      out_target;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_shamt(in_shamt),
        .in_pc(in_pc), .in_rd(in_rd), .flush(flush),
        .alu_instr(alu_instr), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_shamt(alu_shamt), .alu_pc(alu_pc),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rd(out_rd), .out_we(out_we), .out_data(out_data),
        .out_is_mem(out_is_mem), .out_is_store(out_is_store),
        .out_mem_addr(out_mem_addr), .out_store_data(out_store_data),
        .out_redirect(out_redirect), .out_target(out_target)
    );

    // ALU model: inputs registered on the clock, result combinational from them.
    logic [5:0]  a_op;
    logic [31:0] a_rs1, a_rs2, a_imm, a_pc;
    always @(posedge clk) begin
        a_op  <= alu_instr;
        a_rs1 <= alu_rs1;
        a_rs2 <= alu_rs2;
        a_imm <= alu_imm;
        a_pc  <= alu_pc;
    end
    always_comb begin
        alu_result = '0;
        case (a_op)
            i_add:                alu_result = a_rs1 + a_rs2;
            i_addi, i_lw, i_sw:   alu_result = a_rs1 + a_imm;
            i_auipc:              alu_result = a_pc + a_imm;
            i_beq:                alu_result = {31'h2AAA_AAAA, a_rs1 == a_rs2};
            i_bne:                alu_result = {31'h2AAA_AAAA, a_rs1 != a_rs2};
            default:              alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] ins, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] im, input logic [31:0] p, input logic [4:0] d);
        in_valid = 1'b1;
        in_instr = ins;
        in_rs1   = s1;
        in_rs2   = s2;
        in_imm   = im;
        in_pc    = p;
        in_rd    = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_shamt = '0; in_pc = '0; in_rd = '0; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_alu_rs1", alu_rs1, 0);
        rst = 1'b1;
        step();
        chk("rel_in_ready", in_ready, 1);

        // ADD: latency T+3
        issue(i_add, 5, 7, 0, 0, 3);
        chk("add_exec_op", alu_instr, i_add);
        chk("add_exec_rs1", alu_rs1, 5);
        chk("add_exec_in_ready", in_ready, 0);
        step();
        chk("add_capt_valid", out_valid, 0);
        step();
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 12);
        chk("add_we", out_we, 1);
        chk("add_redirect", out_redirect, 0);
        chk("add_rd", out_rd, 3);
        step();
        chk("add_after_ready", in_ready, 1);
        chk("add_after_valid", out_valid, 0);

        // BEQ taken
        issue(i_beq, 9, 9, 32'h20, 32'h100, 0);
        step(); step();
        chk("beq_valid", out_valid, 1);
        chk("beq_redirect", out_redirect, 1);
        chk("beq_target", out_target, 32'h120);
        chk("beq_we", out_we, 0);
        step();

        // BNE not taken
        issue(i_bne, 4, 4, 32'h10, 32'h300, 2);
        step(); step();
        chk("bne_redirect", out_redirect, 0);
        chk("bne_we", out_we, 0);
        step();

        // JALR rd=1
        issue(i_jalr, 32'h1003, 0, 4, 32'h200, 1);
        chk("jalr_exec_op", alu_instr, i_addi);
        step(); step();
        chk("jalr_target", out_target, 32'h1006);
        chk("jalr_data", out_data, 32'h204);
        chk("jalr_we", out_we, 1);
        chk("jalr_redirect", out_redirect, 1);
        chk("jalr_instr", out_instr, i_jalr);
        step();

        // JALR rd=0
        issue(i_jalr, 32'h1003, 0, 4, 32'h200, 0);
        step(); step();
        chk("jalr0_we", out_we, 0);
        step();

        // JAL
        issue(i_jal, 0, 0, 32'h40, 32'h400, 5);
        chk("jal_exec_op", alu_instr, i_auipc);
        step(); step();
        chk("jal_target", out_target, 32'h440);
        chk("jal_data", out_data, 32'h404);
        chk("jal_redirect", out_redirect, 1);
        step();

        // LW with backpressure
        out_ready = 1'b0;
        issue(i_lw, 32'h1000, 0, 32'hFFFF_FFFC, 0, 7);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("lw_hold_valid", out_valid, 1);
            chk("lw_hold_addr", out_mem_addr, 32'hFFC);
            chk("lw_hold_in_ready", in_ready, 0);
            step();
        end
        chk("lw_is_mem", out_is_mem, 1);
        chk("lw_we", out_we, 0);
        chk("lw_rd", out_rd, 7);
        out_ready = 1'b1;
        step();
        chk("lw_release_in_ready", in_ready, 1);

        // SW
        issue(i_sw, 32'h2000, 32'hDEAD_BEEF, 8, 0, 0);
        step(); step();
        chk("sw_is_store", out_is_store, 1);
        chk("sw_store_data", out_store_data, 32'hDEAD_BEEF);
        chk("sw_addr", out_mem_addr, 32'h2008);
        step();

        // Flush in EXEC
        issue(i_add, 1, 2, 0, 0, 4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_exec_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("flush_exec_no_valid", out_valid, 0);
            step();
        end

        // in_valid with flush in IDLE is not accepted
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_in_ready", in_ready, 1);

        // Flush in DONE with out_ready=1
        issue(i_add, 1, 1, 0, 0, 6);
        step(); step();
        chk("done_pre_flush_valid", out_valid, 1);
        flush = 1'b1;
        #1;
        chk("done_flush_valid", out_valid, 0);
        step();
        flush = 1'b0;
        #1;
        chk("done_flush_after_valid", out_valid, 0);
        chk("done_flush_after_ready", in_ready, 1);

        // Reset in CAPT
        issue(i_add, 3, 4, 0, 0, 8);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_alu_rs1", alu_rs1, 0);
        chk("mid_rst_out_data", out_data, 0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_rel_ready", in_ready, 1);
        issue(i_add, 20, 22, 0, 0, 9);
        step(); step();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 42);
        chk("post_rst_rd", out_rd, 9);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
